// File: rtl/int_div_warp_ctrl_if.sv
// Issue, scalar-divider and writeback handshakes of the warp divider controller.
// The slave modport is the controller's view; master is the surrounding pipeline's view.
interface int_div_warp_ctrl_if #(
  parameter int XLEN       = 32,
  parameter int NUM_THREAD = 8,
  parameter int WID_W      = 3,
  parameter int REG_W      = 5
);
  // SFU issue path
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [NUM_THREAD*XLEN-1:0] in_a_i;
  logic [NUM_THREAD*XLEN-1:0] in_d_i;
  logic                       in_sign_i;
  logic                       in_rem_i;
  logic [NUM_THREAD-1:0]      in_mask_i;
  logic [WID_W-1:0]           in_wid_i;
  logic [REG_W-1:0]           in_reg_idx_i;

  // scalar divider
  logic [XLEN-1:0]            div_a_o;
  logic [XLEN-1:0]            div_d_o;
  logic                       div_sign_o;
  logic                       div_in_valid_o;
  logic                       div_in_ready_i;
  logic                       div_out_valid_i;
  logic                       div_out_ready_o;
  logic [XLEN-1:0]            div_q_i;
  logic [XLEN-1:0]            div_r_i;

  // writeback
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [NUM_THREAD*XLEN-1:0] out_data_o;
  logic [NUM_THREAD-1:0]      out_mask_o;
  logic [WID_W-1:0]           out_wid_o;
  logic [REG_W-1:0]           out_reg_idx_o;

  modport slave (
    input  in_valid_i, in_a_i, in_d_i, in_sign_i, in_rem_i, in_mask_i, in_wid_i, in_reg_idx_i,
    input  div_in_ready_i, div_out_valid_i, div_q_i, div_r_i,
    input  out_ready_i,
    output in_ready_o,
    output div_a_o, div_d_o, div_sign_o, div_in_valid_o, div_out_ready_o,
    output out_valid_o, out_data_o, out_mask_o, out_wid_o, out_reg_idx_o
  );

  modport master (
    output in_valid_i, in_a_i, in_d_i, in_sign_i, in_rem_i, in_mask_i, in_wid_i, in_reg_idx_i,
    output div_in_ready_i, div_out_valid_i, div_q_i, div_r_i,
    output out_ready_i,
    input  in_ready_o,
    input  div_a_o, div_d_o, div_sign_o, div_in_valid_o, div_out_ready_o,
    input  out_valid_o, out_data_o, out_mask_o, out_wid_o, out_reg_idx_o
  );
endinterface

// File: rtl/int_div_warp_ctrl.sv
// Serialises the active lanes of one vector DIV/REM instruction through a scalar divider
// and returns the packed per-lane results together with the warp id and destination tag.
module int_div_warp_ctrl #(
  parameter int XLEN       = 32,
  parameter int NUM_THREAD = 8,
  parameter int WID_W      = 3,
  parameter int REG_W      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  int_div_warp_ctrl_if.slave bus
);
  localparam int LANE_W = (NUM_THREAD > 1) ? $clog2(NUM_THREAD) : 1;
  localparam int VEC_W  = NUM_THREAD * XLEN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [VEC_W-1:0]      opa_q, opa_d;
  logic [VEC_W-1:0]      opd_q, opd_d;
  logic [VEC_W-1:0]      res_q, res_d;
  logic                  sign_q, sign_d;
  logic                  rem_q, rem_d;
  logic [NUM_THREAD-1:0] mask_q, mask_d;
  logic [NUM_THREAD-1:0] pending_q, pending_d;
  logic [WID_W-1:0]      wid_q, wid_d;
  logic [REG_W-1:0]      reg_idx_q, reg_idx_d;
  logic [LANE_W-1:0]     issued_q, issued_d;

  logic                  in_ready;
  logic                  div_in_valid;
  logic                  div_out_ready;
  logic                  out_valid;
  logic                  accept;
  logic                  capture;
  logic [LANE_W-1:0]     cur_lane;
  logic [NUM_THREAD-1:0] lane_wr;
  logic [NUM_THREAD-1:0] pending_left;
  logic [XLEN-1:0]       wr_data;
  logic [XLEN-1:0]       lane_a [NUM_THREAD];
  logic [XLEN-1:0]       lane_d [NUM_THREAD];

  assign accept       = in_ready & bus.in_valid_i;
  assign capture      = div_out_ready & bus.div_out_valid_i;
  assign wr_data      = rem_q ? bus.div_r_i : bus.div_q_i;
  assign pending_left = pending_q & ~lane_wr;

  // Lowest pending lane wins, so lanes leave in ascending index order.
  always_comb begin
    cur_lane = '0;
    for (int i = NUM_THREAD - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        cur_lane = LANE_W'(i);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_THREAD; gi++) begin : g_lane
    assign lane_a[gi]  = opa_q[gi*XLEN +: XLEN];
    assign lane_d[gi]  = opd_q[gi*XLEN +: XLEN];
    assign lane_wr[gi] = capture && (issued_q == LANE_W'(gi));
    // The buffer is wiped on accept so masked-off lanes always read back as zero.
    assign res_d[gi*XLEN +: XLEN] = accept      ? '0      :
                                    lane_wr[gi] ? wr_data :
                                                  res_q[gi*XLEN +: XLEN];
  end

  always_comb begin
    opa_d     = opa_q;
    opd_d     = opd_q;
    sign_d    = sign_q;
    rem_d     = rem_q;
    mask_d    = mask_q;
    wid_d     = wid_q;
    reg_idx_d = reg_idx_q;
    pending_d = pending_q;
    if (accept) begin
      opa_d     = bus.in_a_i;
      opd_d     = bus.in_d_i;
      sign_d    = bus.in_sign_i;
      rem_d     = bus.in_rem_i;
      mask_d    = bus.in_mask_i;
      wid_d     = bus.in_wid_i;
      reg_idx_d = bus.in_reg_idx_i;
      pending_d = bus.in_mask_i;
    end else if (capture) begin
      pending_d = pending_left;
    end
  end

  always_comb begin
    state_d       = state_q;
    issued_d      = issued_q;
    in_ready      = 1'b0;
    div_in_valid  = 1'b0;
    div_out_ready = 1'b0;
    out_valid     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid_i) begin
          state_d = (|bus.in_mask_i) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        div_in_valid = 1'b1;
        if (bus.div_in_ready_i) begin
          issued_d = cur_lane;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        div_out_ready = 1'b1;
        if (bus.div_out_valid_i) begin
          state_d = (|pending_left) ? ISSUE : DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opa_q     <= '0;
      opd_q     <= '0;
      res_q     <= '0;
      sign_q    <= 1'b0;
      rem_q     <= 1'b0;
      mask_q    <= '0;
      pending_q <= '0;
      wid_q     <= '0;
      reg_idx_q <= '0;
      issued_q  <= '0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opd_q     <= opd_d;
      res_q     <= res_d;
      sign_q    <= sign_d;
      rem_q     <= rem_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      wid_q     <= wid_d;
      reg_idx_q <= reg_idx_d;
      issued_q  <= issued_d;
    end
  end

  // Divider operands are forced to zero outside ISSUE so idle outputs stay quiet.
  assign bus.in_ready_o      = in_ready;
  assign bus.div_in_valid_o  = div_in_valid;
  assign bus.div_a_o         = div_in_valid ? lane_a[cur_lane] : '0;
  assign bus.div_d_o         = div_in_valid ? lane_d[cur_lane] : '0;
  assign bus.div_sign_o      = div_in_valid & sign_q;
  assign bus.div_out_ready_o = div_out_ready;
  assign bus.out_valid_o     = out_valid;
  assign bus.out_data_o      = res_q;
  assign bus.out_mask_o      = mask_q;
  assign bus.out_wid_o       = wid_q;
  assign bus.out_reg_idx_o   = reg_idx_q;
endmodule

// File: tb/tb_int_div_warp_ctrl.sv
// Self-checking bench for int_div_warp_ctrl: a behavioural scalar divider answers the
// issue handshake, and every vector result is compared with values computed here.
module tb_int_div_warp_ctrl;
  localparam int XLEN  = 32;
  localparam int NT    = 8;
  localparam int WID_W = 3;
  localparam int REG_W = 5;
  localparam int VW    = NT * XLEN;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  int_div_warp_ctrl_if #(.XLEN(XLEN), .NUM_THREAD(NT), .WID_W(WID_W), .REG_W(REG_W)) bus ();

  int_div_warp_ctrl #(.XLEN(XLEN), .NUM_THREAD(NT), .WID_W(WID_W), .REG_W(REG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] d;
    logic            sign;
  } op_t;

  op_t issue_q[$];   // operands the divider should see, in issue order
  int  in_stall = 0; // forced cycles of div_in_ready_i low

  // RISC-V integer divide semantics, including the divide-by-zero and overflow cases.
  function automatic logic [XLEN-1:0] ref_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d,
                                             input logic sgn, input logic rem);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sd;
    logic [XLEN-1:0]        int_min;
    sa      = a;
    sd      = d;
    int_min = {1'b1, {(XLEN-1){1'b0}}};
    if (d == '0) return rem ? a : '1;
    if (sgn) begin
      if (a == int_min && d == '1) return rem ? '0 : a;
      return rem ? XLEN'(sa % sd) : XLEN'(sa / sd);
    end
    return rem ? (a % d) : (a / d);
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural scalar divider: one operation at a time, 0..3 cycles of latency.
  logic            mdl_busy;
  int              mdl_lat;
  logic            prev_stall;
  logic [XLEN-1:0] prev_a, prev_d;

  initial begin
    logic            fire_in, fire_out;
    op_t             exp_op;
    logic [XLEN-1:0] cap_a, cap_d;
    logic            cap_s;
    bus.div_in_ready_i  = 1'b0;
    bus.div_out_valid_i = 1'b0;
    bus.div_q_i         = '0;
    bus.div_r_i         = '0;
    mdl_busy   = 1'b0;
    mdl_lat    = 0;
    prev_stall = 1'b0;
    prev_a     = '0;
    prev_d     = '0;
    cap_a      = '0;
    cap_d      = '0;
    cap_s      = 1'b0;
    forever begin
      @(negedge clk);
      fire_in  = 1'b0;
      fire_out = 1'b0;
      if (rst_n) begin
        fire_in  = bus.div_in_valid_o && bus.div_in_ready_i;
        fire_out = bus.div_out_valid_i && bus.div_out_ready_o;
        if (bus.div_out_valid_i) chk("div_out_ready_when_valid", VW'(bus.div_out_ready_o), VW'(1));
        if (prev_stall) begin
          chk("div_in_valid_hold", VW'(bus.div_in_valid_o), VW'(1));
          chk("div_a_hold", VW'(bus.div_a_o), VW'(prev_a));
          chk("div_d_hold", VW'(bus.div_d_o), VW'(prev_d));
        end
        prev_stall = bus.div_in_valid_o && !bus.div_in_ready_i;
        prev_a     = bus.div_a_o;
        prev_d     = bus.div_d_o;
        if (fire_in) begin
          checks++;
          assert (issue_q.size() > 0)
          else begin
            errors++;
            $error("FAIL unexpected_issue observed=%0h expected=no_issue", bus.div_a_o);
          end
          if (issue_q.size() > 0) begin
            exp_op = issue_q.pop_front();
            chk("issue_a", VW'(bus.div_a_o), VW'(exp_op.a));
            chk("issue_d", VW'(bus.div_d_o), VW'(exp_op.d));
            chk("issue_sign", VW'(bus.div_sign_o), VW'(exp_op.sign));
          end
          cap_a = bus.div_a_o;
          cap_d = bus.div_d_o;
          cap_s = bus.div_sign_o;
        end
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mdl_busy            = 1'b0;
        bus.div_out_valid_i = 1'b0;
        bus.div_in_ready_i  = 1'b0;
        prev_stall          = 1'b0;
        continue;
      end
      if (fire_out) begin
        bus.div_out_valid_i = 1'b0;
        mdl_busy            = 1'b0;
      end
      if (fire_in) begin
        mdl_busy    = 1'b1;
        mdl_lat     = $urandom_range(0, 3);
        bus.div_q_i = ref_op(cap_a, cap_d, cap_s, 1'b0);
        bus.div_r_i = ref_op(cap_a, cap_d, cap_s, 1'b1);
      end
      if (mdl_busy && !bus.div_out_valid_i) begin
        if (mdl_lat == 0) bus.div_out_valid_i = 1'b1;
        else mdl_lat--;
      end
      if (mdl_busy) begin
        bus.div_in_ready_i = 1'b0;
      end else if (in_stall > 0) begin
        bus.div_in_ready_i = 1'b0;
        in_stall--;
      end else begin
        bus.div_in_ready_i = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "/in_ready"}, VW'(bus.in_ready_o), VW'(1));
    chk({tag, "/out_valid"}, VW'(bus.out_valid_o), VW'(0));
    chk({tag, "/div_in_valid"}, VW'(bus.div_in_valid_o), VW'(0));
    chk({tag, "/div_out_ready"}, VW'(bus.div_out_ready_o), VW'(0));
    chk({tag, "/div_a"}, VW'(bus.div_a_o), VW'(0));
    chk({tag, "/div_d"}, VW'(bus.div_d_o), VW'(0));
    chk({tag, "/div_sign"}, VW'(bus.div_sign_o), VW'(0));
    chk({tag, "/out_data"}, bus.out_data_o, VW'(0));
    chk({tag, "/out_mask"}, VW'(bus.out_mask_o), VW'(0));
    chk({tag, "/out_wid"}, VW'(bus.out_wid_o), VW'(0));
    chk({tag, "/out_reg_idx"}, VW'(bus.out_reg_idx_o), VW'(0));
  endtask

  // Queues the expected issue sequence, presents the instruction and returns the expected data.
  task automatic send(input string tag, input logic [VW-1:0] a, input logic [VW-1:0] d,
                      input logic sgn, input logic rem, input logic [NT-1:0] mask,
                      input logic [WID_W-1:0] wid, input logic [REG_W-1:0] rix,
                      output logic [VW-1:0] exp);
    exp = '0;
    for (int i = 0; i < NT; i++) begin
      if (mask[i]) begin
        exp[i*XLEN +: XLEN] = ref_op(a[i*XLEN +: XLEN], d[i*XLEN +: XLEN], sgn, rem);
        issue_q.push_back('{a: a[i*XLEN +: XLEN], d: d[i*XLEN +: XLEN], sign: sgn});
      end
    end
    @(negedge clk);
    chk({tag, "/in_ready_idle"}, VW'(bus.in_ready_o), VW'(1));
    bus.in_a_i       = a;
    bus.in_d_i       = d;
    bus.in_sign_i    = sgn;
    bus.in_rem_i     = rem;
    bus.in_mask_i    = mask;
    bus.in_wid_i     = wid;
    bus.in_reg_idx_i = rix;
    bus.in_valid_i   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic run_instr(input string tag, input logic [VW-1:0] a, input logic [VW-1:0] d,
                           input logic sgn, input logic rem, input logic [NT-1:0] mask,
                           input logic [WID_W-1:0] wid, input logic [REG_W-1:0] rix,
                           input int out_hold);
    logic [VW-1:0] exp;
    int            cyc;
    send(tag, a, d, sgn, rem, mask, wid, rix, exp);
    cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid_o) break;
      chk({tag, "/in_ready_busy"}, VW'(bus.in_ready_o), VW'(0));
    end
    chk({tag, "/out_valid"}, VW'(bus.out_valid_o), VW'(1));
    if (!bus.out_valid_o) begin
      issue_q.delete();
      return;
    end
    if (mask == '0) chk({tag, "/empty_mask_latency"}, VW'(cyc), VW'(1));
    // Writeback stall; a competing instruction is offered meanwhile and must be ignored.
    for (int k = 0; k < out_hold; k++) begin
      chk({tag, "/hold_valid"}, VW'(bus.out_valid_o), VW'(1));
      chk({tag, "/hold_data"}, bus.out_data_o, exp);
      chk({tag, "/hold_in_ready"}, VW'(bus.in_ready_o), VW'(0));
      bus.in_wid_i   = ~wid;
      bus.in_mask_i  = ~mask;
      bus.in_valid_i = 1'b1;
      @(negedge clk);
    end
    bus.in_valid_i = 1'b0;
    chk({tag, "/out_data"}, bus.out_data_o, exp);
    chk({tag, "/out_mask"}, VW'(bus.out_mask_o), VW'(mask));
    chk({tag, "/out_wid"}, VW'(bus.out_wid_o), VW'(wid));
    chk({tag, "/out_reg_idx"}, VW'(bus.out_reg_idx_o), VW'(rix));
    chk({tag, "/lanes_issued"}, VW'(issue_q.size()), VW'(0));
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
    @(negedge clk);
    chk({tag, "/back_to_idle"}, VW'(bus.in_ready_o), VW'(1));
    chk({tag, "/out_valid_drop"}, VW'(bus.out_valid_o), VW'(0));
    $display("txn %s sign=%0d rem=%0d mask=%02h wid=%0d reg=%0d cycles=%0d", tag, sgn, rem, mask,
             wid, rix, cyc);
    issue_q.delete();
  endtask

  task automatic rand_vec(output logic [VW-1:0] a, output logic [VW-1:0] d);
    for (int i = 0; i < NT; i++) begin
      a[i*XLEN +: XLEN] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       d[i*XLEN +: XLEN] = '0;
        1:       d[i*XLEN +: XLEN] = $urandom_range(1, 9);
        2:       d[i*XLEN +: XLEN] = '1;
        default: d[i*XLEN +: XLEN] = $urandom;
      endcase
    end
  endtask

  initial begin
    logic [VW-1:0] va, vd, vexp;
    int            wcyc;
    bus.in_valid_i   = 1'b0;
    bus.in_a_i       = '0;
    bus.in_d_i       = '0;
    bus.in_sign_i    = 1'b0;
    bus.in_rem_i     = 1'b0;
    bus.in_mask_i    = '0;
    bus.in_wid_i     = '0;
    bus.in_reg_idx_i = '0;
    bus.out_ready_i  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Unsigned single lane: 100 / 7 -> q=14, r=2
    va = '0; vd = '0;
    va[0 +: XLEN] = 32'd100;
    vd[0 +: XLEN] = 32'd7;
    run_instr("udiv_q", va, vd, 1'b0, 1'b0, 8'h01, 3'd1, 5'd3, 0);
    run_instr("udiv_r", va, vd, 1'b0, 1'b1, 8'h01, 3'd2, 5'd4, 1);

    // Signed lanes 0 and 2, including INT_MIN / -1
    va = '0; vd = '0;
    va[0 +: XLEN]      = 32'hFFFF_FFF9;
    vd[0 +: XLEN]      = 32'd2;
    va[2*XLEN +: XLEN] = 32'h8000_0000;
    vd[2*XLEN +: XLEN] = 32'hFFFF_FFFF;
    run_instr("sdiv_q", va, vd, 1'b1, 1'b0, 8'h05, 3'd3, 5'd9, 0);
    run_instr("sdiv_r", va, vd, 1'b1, 1'b1, 8'h05, 3'd3, 5'd9, 0);

    // Divide by zero on every lane, a = lane index
    va = '0; vd = '0;
    for (int i = 0; i < NT; i++) va[i*XLEN +: XLEN] = XLEN'(i);
    run_instr("divzero_q", va, vd, 1'b0, 1'b0, 8'hFF, 3'd4, 5'd1, 0);
    run_instr("divzero_r", va, vd, 1'b1, 1'b1, 8'hFF, 3'd4, 5'd2, 0);

    // Empty mask: straight to DONE
    rand_vec(va, vd);
    run_instr("mask_zero", va, vd, 1'b0, 1'b0, 8'h00, 3'd5, 5'd17, 0);

    // Backpressure: ready is forced low long enough to span at least 3 ISSUE cycles
    in_stall = 5;
    rand_vec(va, vd);
    run_instr("backpressure", va, vd, 1'b1, 1'b0, 8'h81, 3'd6, 5'd30, 4);

    // Reset while waiting on the divider, then a clean instruction
    rand_vec(va, vd);
    send("reset_mid", va, vd, 1'b0, 1'b0, 8'hFF, 3'd7, 5'd12, vexp);
    wcyc = 0;
    while (wcyc < 100 && !bus.div_out_ready_o) begin
      @(negedge clk);
      wcyc++;
    end
    chk("reset_mid/reached_wait", VW'(bus.div_out_ready_o), VW'(1));
    #2 rst_n = 1'b0;
    #1;
    check_reset("reset_mid");
    issue_q.delete();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    rand_vec(va, vd);
    run_instr("after_reset", va, vd, 1'b1, 1'b1, 8'hFF, 3'd2, 5'd21, 0);

    for (int n = 0; n < 25; n++) begin
      rand_vec(va, vd);
      run_instr($sformatf("rand%0d", n), va, vd, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), NT'($urandom), WID_W'($urandom), REG_W'($urandom),
                $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/int_div_warp_ctrl.md
Name: int_div_warp_ctrl

Overview:
- Warp-level front/back end for the scalar integer divider.
- Accepts one vector divide/remainder instruction (NUM_THREAD lanes) from the SFU issue path.
- Issues the active lanes one at a time into the scalar divider over its valid/ready handshake, and collects the quotient or remainder of each lane.
- Returns one packed vector result with the warp id and destination register tag to writeback.

Parameters:
XLEN, 32, data width per lane
NUM_THREAD, 8, lanes per warp
WID_W, 3, warp id width
REG_W, 5, destination register index width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid_i  input  1  instruction valid
in_ready_o  output  1  block can accept an instruction
in_a_i  input  NUM_THREAD*XLEN  dividends; lane i at [i*XLEN +: XLEN]
in_d_i  input  NUM_THREAD*XLEN  divisors; same packing as in_a_i
in_sign_i  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
in_rem_i  input  1  1 = return remainder, 0 = return quotient
in_mask_i  input  NUM_THREAD  active-lane mask
in_wid_i  input  WID_W  warp id
in_reg_idx_i  input  REG_W  destination register
div_a_o  output  XLEN  dividend to scalar divider
div_d_o  output  XLEN  divisor to scalar divider
div_sign_o  output  1  sign mode to scalar divider
div_in_valid_o  output  1  operand valid to divider
div_in_ready_i  input  1  divider accepts operands
div_out_valid_i  input  1  divider result valid
div_out_ready_o  output  1  block accepts divider result
div_q_i  input  XLEN  divider quotient
div_r_i  input  XLEN  divider remainder
out_valid_o  output  1  vector result valid
out_ready_i  input  1  writeback accepts the result
out_data_o  output  NUM_THREAD*XLEN  per-lane results
out_mask_o  output  NUM_THREAD  copy of the captured mask
out_wid_o  output  WID_W  captured warp id
out_reg_idx_o  output  REG_W  captured destination register

Behaviour:
- Reset (async, rst_n low): state IDLE, pending = 0. All outputs are 0 except in_ready_o = 1. Reset mid-operation abandons the instruction; nothing is replayed.
- State machine: IDLE, ISSUE, WAIT, DONE. in_ready_o = (state == IDLE).
- IDLE:
  - On in_valid_i & in_ready_o, capture operands, sign, rem, mask, wid and reg_idx.
  - Set pending = in_mask_i and clear the result buffer to 0.
  - Next state is ISSUE if in_mask_i != 0, otherwise DONE.
- ISSUE:
  - cur_lane = lowest-index set bit of pending.
  - div_a_o / div_d_o = captured operands of cur_lane; div_sign_o = captured sign; div_in_valid_o = 1.
  - On div_in_ready_i, latch cur_lane as issued_lane and go to WAIT.
  - div_in_valid_o and the operands stay stable until accepted.
- WAIT:
  - div_out_ready_o = 1, div_in_valid_o = 0.
  - On div_out_valid_i, write (rem ? div_r_i : div_q_i) into lane issued_lane of the result buffer and clear that pending bit.
  - Next state is ISSUE if any pending bit remains, else DONE.
- DONE:
  - out_valid_o = 1; out_data_o, out_mask_o, out_wid_o, out_reg_idx_o are driven from registers.
  - Hold until out_ready_i, then return to IDLE.
  - No new instruction is accepted in DONE; a new instruction may be accepted in the cycle after the IDLE return.
- Masked-off lanes are never issued and read as 0 in out_data_o.
- Special-case values (divide-by-zero, signed overflow, |a|<|d|) are produced by the divider and passed through unmodified.
- Latency overhead per active lane: 1 cycle ISSUE plus divider latency plus 1 cycle WAIT capture. For an all-zero mask, out_valid_o rises 1 cycle after acceptance.
- div_out_valid_i outside WAIT is ignored, with div_out_ready_o = 0. It cannot occur in a correct system; the bench asserts this.
- Simultaneous events: in DONE, out_ready_i is the only exit; in_valid_i is ignored.

Test Plan:
- Unsigned, mask=0x01, lane0 a=100 d=7, rem=0 -> out_data lane0=14, other lanes 0, out_mask=0x01; with rem=1 -> lane0=2.
- Signed, mask=0x05: lane0 a=-7 (0xFFFFFFF9) d=2; lane2 a=0x80000000 d=0xFFFFFFFF -> quotients lane0=0xFFFFFFFD, lane2=0x80000000; lanes issued in order 0 then 2.
- Divide by zero, mask=0xFF, all d=0, a=i -> quotient mode: every lane 0xFFFFFFFF; remainder mode: lane i = i.
- mask=0x00, wid=5, reg=17 -> out_valid_o 1 cycle after accept; data 0; wid=5, reg_idx=17.
- Backpressure: div_in_ready_i low for 3 cycles and out_ready_i low for 4 cycles -> div_a_o/div_d_o and the vector output stay stable; in_ready_o stays 0 until the DONE handshake.
- Assert rst_n low in WAIT with mask=0xFF -> all outputs reset immediately; a following instruction completes correctly.
